// File: rtl/servo_ramp_pkg.sv
// Shared constants and types for the servo slew-rate limiter.
//   CLK_HZ / SERVO_FRAME_CYCLES : system clock and 20 ms servo frame length
//   SERVO_W                     : width of one servo position
//   ARM_NUM_SERVOS              : servo channels on the arm
//   SERVO_CENTRE                : neutral position used after reset
//   state_t                     : update sequencer states
package servo_ramp_pkg;

  localparam int CLK_HZ             = 12000000;
  localparam int SERVO_FRAME_CYCLES = 240000;
  localparam int SERVO_W            = 8;
  localparam int ARM_NUM_SERVOS     = 4;
  localparam int SERVO_CENTRE       = 127;

  typedef enum logic {
    IDLE   = 1'b0,
    UPDATE = 1'b1
  } state_t;

endpackage

// File: rtl/servo_ramp_if.sv
// Command port of the servo slew-rate limiter (valid/ready).
//   cmd_valid  : host has a command
//   cmd_ready  : limiter can take a command this cycle
//   cmd_ch     : channel index the new target applies to
//   cmd_target : new target position
// master = host side, slave = servo_ramp side.
interface servo_ramp_if
  import servo_ramp_pkg::*;
#(
  parameter int CH_W = 2
);

  logic               cmd_valid;
  logic               cmd_ready;
  logic [CH_W-1:0]    cmd_ch;
  logic [SERVO_W-1:0] cmd_target;

  modport master (
    output cmd_valid,
    output cmd_ch,
    output cmd_target,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_ch,
    input  cmd_target,
    output cmd_ready
  );

endinterface

// File: rtl/servo_ramp_slew_step.sv
// slew_step: combinational one-frame move of a position toward its target.
//   pos      : current position
//   tgt      : target position
//   next_pos : pos moved toward tgt by at most STEP, never passing tgt
module slew_step
  import servo_ramp_pkg::*;
#(
  parameter int STEP = 2
) (
  input  logic [SERVO_W-1:0] pos,
  input  logic [SERVO_W-1:0] tgt,
  output logic [SERVO_W-1:0] next_pos
);

  localparam logic [SERVO_W:0]   STEP_EXT = (SERVO_W+1)'(STEP);
  localparam logic [SERVO_W-1:0] STEP_POS = SERVO_W'(STEP);

  logic [SERVO_W:0] diff;
  logic [SERVO_W:0] mag;
  logic             down;

  // 9-bit two's-complement difference; its top bit is the direction.
  always_comb begin
    diff = {1'b0, tgt} - {1'b0, pos};
    down = diff[SERVO_W];
    mag  = down ? (~diff + 1'b1) : diff;
    if (mag <= STEP_EXT) begin
      next_pos = tgt;
    end else if (!down) begin
      next_pos = pos + STEP_POS;
    end else begin
      next_pos = pos - STEP_POS;
    end
  end

endmodule

// File: rtl/servo_ramp.sv
// servo_ramp: slew-rate limiter feeding the servo PWM stages.
// Targets arrive over the command port; once per frame every channel's
// position steps toward its target by at most STEP counts.
//   clk, rst   : 12 MHz clock, asynchronous active-high reset
//   cmd        : command port (slave side), see servo_ramp_if
//   value      : all positions, channel k at value[8k+7:8k]
//   frame_tick : one-cycle pulse in the last cycle of each frame
//   busy       : some position has not yet reached its target
module servo_ramp
  import servo_ramp_pkg::*;
#(
  parameter int NUM_CH       = ARM_NUM_SERVOS,
  parameter int CH_W         = 2,
  parameter int FRAME_CYCLES = SERVO_FRAME_CYCLES,
  parameter int STEP         = 2,
  parameter int INIT_VALUE   = SERVO_CENTRE
) (
  input  logic                      clk,
  input  logic                      rst,
  servo_ramp_if.slave               cmd,
  output logic [NUM_CH*SERVO_W-1:0] value,
  output logic                      frame_tick,
  output logic                      busy
);

  localparam int                 CNT_W      = $clog2(FRAME_CYCLES);
  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(FRAME_CYCLES - 1);
  localparam logic [CH_W-1:0]    IDX_LAST   = CH_W'(NUM_CH - 1);
  localparam logic [CH_W:0]      NUM_CH_EXT = (CH_W+1)'(NUM_CH);
  localparam logic [SERVO_W-1:0] INIT_POS   = SERVO_W'(INIT_VALUE);

  logic [CNT_W-1:0]   frame_cnt;
  state_t             state;
  logic [CH_W-1:0]    idx;
  logic               ready_q;
  logic [SERVO_W-1:0] pos [NUM_CH];
  logic [SERVO_W-1:0] tgt [NUM_CH];
  logic [SERVO_W-1:0] slot_pos;
  logic [SERVO_W-1:0] slot_tgt;
  logic [SERVO_W-1:0] slot_next;
  logic               cmd_fire;
  logic               cmd_ch_ok;

  assign frame_tick = (frame_cnt == CNT_LAST);

  // The registered ready resets high so it is already 1 in the first cycle
  // after release; masking with rst keeps it low while reset is held.
  assign cmd.cmd_ready = ready_q & ~rst;
  assign cmd_fire      = cmd.cmd_valid & ready_q;

  // Extra bit so NUM_CH == 2**CH_W still compares correctly.
  assign cmd_ch_ok = ({1'b0, cmd.cmd_ch} < NUM_CH_EXT);

  // One slew calculator shared by all channels through the idx mux.
  assign slot_pos = pos[idx];
  assign slot_tgt = tgt[idx];

  slew_step #(
    .STEP (STEP)
  ) u_slew_step (
    .pos      (slot_pos),
    .tgt      (slot_tgt),
    .next_pos (slot_next)
  );

  for (genvar k = 0; k < NUM_CH; k++) begin : g_value
    assign value[k*SERVO_W +: SERVO_W] = pos[k];
  end

  always_comb begin
    busy = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (pos[k] != tgt[k]) begin
        busy = 1'b1;
      end
    end
  end

  // Frame counter plus IDLE/UPDATE sequencer. Commands are only taken in
  // IDLE, which includes the tick cycle, so a command landing on the tick
  // is already in tgt when the sweep starts. The sweep touches one channel
  // per cycle, so UPDATE lasts exactly NUM_CH cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= '0;
      state     <= IDLE;
      idx       <= '0;
      ready_q   <= 1'b1;
      for (int k = 0; k < NUM_CH; k++) begin
        pos[k] <= INIT_POS;
        tgt[k] <= INIT_POS;
      end
    end else begin
      frame_cnt <= frame_tick ? '0 : frame_cnt + CNT_W'(1);
      case (state)
        IDLE: begin
          if (cmd_fire && cmd_ch_ok) begin
            tgt[cmd.cmd_ch] <= cmd.cmd_target;
          end
          if (frame_tick) begin
            state   <= UPDATE;
            idx     <= '0;
            ready_q <= 1'b0;
          end
        end
        UPDATE: begin
          pos[idx] <= slot_next;
          if (idx == IDX_LAST) begin
            state   <= IDLE;
            idx     <= '0;
            ready_q <= 1'b1;
          end else begin
            idx <= idx + CH_W'(1);
          end
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_servo_ramp.sv
// Testbench for servo_ramp: directed scenarios plus random commands, with a
// frame-level reference model feeding a scoreboard that a separate monitor
// drains while each update sweep is in progress.
module tb_servo_ramp;

  localparam int NUM_CH  = 4;
  localparam int CH_W    = 2;
  localparam int FRAME   = 64;
  localparam int STEP    = 2;
  localparam int INIT    = 127;
  localparam int NUM_CH3 = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  servo_ramp_if #(.CH_W(CH_W)) cmd_if ();
  servo_ramp_if #(.CH_W(CH_W)) cmd3_if ();

  logic [NUM_CH*8-1:0]  value;
  logic                 frame_tick;
  logic                 busy;
  logic [NUM_CH3*8-1:0] value3;
  logic                 frame_tick3;
  logic                 busy3;

  servo_ramp #(
    .NUM_CH       (NUM_CH),
    .CH_W         (CH_W),
    .FRAME_CYCLES (FRAME),
    .STEP         (STEP),
    .INIT_VALUE   (INIT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd        (cmd_if.slave),
    .value      (value),
    .frame_tick (frame_tick),
    .busy       (busy)
  );

  // Three-channel copy so an out-of-range channel index can be sent.
  servo_ramp #(
    .NUM_CH       (NUM_CH3),
    .CH_W         (CH_W),
    .FRAME_CYCLES (FRAME),
    .STEP         (STEP),
    .INIT_VALUE   (INIT)
  ) dut3 (
    .clk        (clk),
    .rst        (rst),
    .cmd        (cmd3_if.slave),
    .value      (value3),
    .frame_tick (frame_tick3),
    .busy       (busy3)
  );

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] oldv;
    logic [31:0] newv;
    logic        busy;
  } exp_t;

  exp_t expQ[$];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, need 0x%0h", name, actual, expected);
    end
  endtask

  task automatic failNow(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: wait bound expired", name);
  endtask

  // One frame of motion expressed as "close the gap, capped at STEP".
  function automatic int approach(input int p, input int t);
    if (t > p) return (t - p > STEP) ? p + STEP : t;
    else       return (p - t > STEP) ? p - STEP : t;
  endfunction

  // Reference model: frame timing, ready window and per-frame positions.
  int   mpos [NUM_CH];
  int   mtgt [NUM_CH];
  int   mcnt;
  int   since;
  bit   mTick;
  bit   mReady;
  exp_t mExp;

  always @(negedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_CH; k++) begin
        mpos[k] = INIT;
        mtgt[k] = INIT;
      end
      mcnt  = 0;
      since = NUM_CH + 1;
      expQ.delete();
    end else begin
      mTick  = (mcnt == FRAME - 1);
      mReady = !(since >= 1 && since <= NUM_CH);
      checkOutput("frame_tick", 32'(frame_tick), 32'(mTick));
      checkOutput("cmd_ready", 32'(cmd_if.cmd_ready), 32'(mReady));
      if (cmd_if.cmd_valid && mReady && int'(cmd_if.cmd_ch) < NUM_CH) begin
        mtgt[cmd_if.cmd_ch] = int'(cmd_if.cmd_target);
      end
      if (mTick) begin
        mExp.busy = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
          mExp.oldv[k*8 +: 8] = 8'(mpos[k]);
          mpos[k] = approach(mpos[k], mtgt[k]);
          mExp.newv[k*8 +: 8] = 8'(mpos[k]);
          if (mpos[k] != mtgt[k]) mExp.busy = 1'b1;
        end
        expQ.push_back(mExp);
        since = 1;
      end else if (since <= NUM_CH) begin
        since++;
      end
      mcnt = (mcnt == FRAME - 1) ? 0 : mcnt + 1;
    end
  end

  // Monitor: after each DUT tick, channel k must switch from old to new
  // value exactly when the sweep reaches it.
  bit          monActive = 1'b0;
  bit          monTickSeen = 1'b0;
  int          monPhase;
  exp_t        monCur;
  logic [31:0] monWant;

  always @(negedge clk) begin
    if (rst) begin
      monActive   = 1'b0;
      monTickSeen = 1'b0;
    end else begin
      if (monTickSeen) begin
        if (expQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL scoreboard_underflow: got tick, need no tick");
          monActive = 1'b0;
        end else begin
          monCur    = expQ.pop_front();
          monActive = 1'b1;
          monPhase  = 0;
        end
        monTickSeen = 1'b0;
      end
      if (monActive) begin
        for (int k = 0; k < NUM_CH; k++) begin
          monWant[k*8 +: 8] = (k < monPhase) ? monCur.newv[k*8 +: 8]
                                             : monCur.oldv[k*8 +: 8];
        end
        checkOutput($sformatf("value_phase%0d", monPhase), value, monWant);
        if (monPhase == NUM_CH) begin
          checkOutput("busy_after_update", 32'(busy), 32'(monCur.busy));
          monActive = 1'b0;
        end
        monPhase++;
      end
      if (frame_tick) monTickSeen = 1'b1;
    end
  end

  task automatic applyStimulus(input bit waitEdge, input logic [1:0] ch,
                               input logic [7:0] tgt, output int stalls,
                               output bit tickAtAccept);
    bit done;
    if (waitEdge) begin
      @(posedge clk);
      #1;
    end
    cmd_if.cmd_valid  = 1'b1;
    cmd_if.cmd_ch     = ch;
    cmd_if.cmd_target = tgt;
    stalls       = 0;
    tickAtAccept = 1'b0;
    done         = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (cmd_if.cmd_ready) begin
        done         = 1'b1;
        tickAtAccept = frame_tick;
      end else begin
        stalls++;
      end
    end
    if (!done) failNow("cmd_handshake");
    @(posedge clk);
    #1;
    cmd_if.cmd_valid = 1'b0;
  endtask

  // Returns at the first cycle in which the whole sweep is visible.
  task automatic waitTick();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2 * FRAME && !ok; i++) begin
      @(negedge clk);
      if (frame_tick) ok = 1'b1;
    end
    if (!ok) failNow("frame_tick_wait");
    else repeat (NUM_CH + 1) @(negedge clk);
  endtask

  initial begin
    int   st;
    bit   tk;
    bit   done3;
    int   cyc;
    logic [1:0] rch;
    logic [7:0] rtg;

    cmd_if.cmd_valid   = 1'b0;
    cmd_if.cmd_ch      = '0;
    cmd_if.cmd_target  = '0;
    cmd3_if.cmd_valid  = 1'b0;
    cmd3_if.cmd_ch     = '0;
    cmd3_if.cmd_target = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_value", value, 32'h7F7F7F7F);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_tick", 32'(frame_tick), 32'd0);
    checkOutput("reset_ready", 32'(cmd_if.cmd_ready), 32'd0);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_release", 32'(cmd_if.cmd_ready), 32'd1);

    // Ramp up ch1 127 -> 137
    applyStimulus(1'b1, 2'd1, 8'd137, st, tk);
    for (int i = 0; i < 5; i++) begin
      waitTick();
      checkOutput($sformatf("ramp_ch1_%0d", i), 32'(value[15:8]), 32'(129 + 2 * i));
      checkOutput($sformatf("ramp_busy_%0d", i), 32'(busy), (i < 4) ? 32'd1 : 32'd0);
    end
    checkOutput("ramp_others", value, 32'h7F7F897F);

    // Down with odd landing, then 1 -> 0
    applyStimulus(1'b1, 2'd0, 8'd124, st, tk);
    waitTick();
    checkOutput("down_ch0_a", 32'(value[7:0]), 32'd125);
    waitTick();
    checkOutput("down_ch0_b", 32'(value[7:0]), 32'd124);
    applyStimulus(1'b1, 2'd0, 8'd1, st, tk);
    repeat (62) waitTick();
    checkOutput("down_ch0_to1", 32'(value[7:0]), 32'd1);
    applyStimulus(1'b1, 2'd0, 8'd0, st, tk);
    waitTick();
    checkOutput("down_ch0_to0", 32'(value[7:0]), 32'd0);

    // Command in the tick cycle, then one stalled by the sweep
    repeat (FRAME - NUM_CH - 2) @(negedge clk);
    applyStimulus(1'b1, 2'd3, 8'd60, st, tk);
    checkOutput("tick_cmd_stalls", 32'(st), 32'd0);
    checkOutput("tick_cmd_on_tick", 32'(tk), 32'd1);
    applyStimulus(1'b0, 2'd2, 8'd140, st, tk);
    checkOutput("update_stall_cycles", 32'(st), 32'(NUM_CH));
    checkOutput("tick_cmd_applied", 32'(value[31:24]), 32'd125);
    checkOutput("late_cmd_deferred", 32'(value[23:16]), 32'd127);
    waitTick();
    checkOutput("late_cmd_next_frame", 32'(value[23:16]), 32'd129);
    checkOutput("tick_cmd_second", 32'(value[31:24]), 32'd123);

    // Out-of-range channel on the three-channel instance
    @(posedge clk);
    #1;
    cmd3_if.cmd_valid  = 1'b1;
    cmd3_if.cmd_ch     = 2'd3;
    cmd3_if.cmd_target = 8'd200;
    done3 = 1'b0;
    for (int i = 0; i < 20 && !done3; i++) begin
      @(negedge clk);
      if (cmd3_if.cmd_ready) done3 = 1'b1;
    end
    @(posedge clk);
    #1;
    cmd3_if.cmd_valid = 1'b0;
    checkOutput("invalid_ch_handshake", 32'(done3), 32'd1);
    checkOutput("invalid_ch_busy", 32'(busy3), 32'd0);
    waitTick();
    checkOutput("invalid_ch_value", 32'(value3), 32'h007F7F7F);
    checkOutput("invalid_ch_busy_frame", 32'(busy3), 32'd0);

    // Reset in the middle of a sweep
    applyStimulus(1'b1, 2'd2, 8'd200, st, tk);
    waitTick();
    tk = 1'b0;
    for (int i = 0; i < 2 * FRAME && !tk; i++) begin
      @(negedge clk);
      if (frame_tick) tk = 1'b1;
    end
    if (!tk) failNow("pre_reset_tick");
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("midreset_value", value, 32'h7F7F7F7F);
    checkOutput("midreset_busy", 32'(busy), 32'd0);
    checkOutput("midreset_tick", 32'(frame_tick), 32'd0);
    checkOutput("midreset_ready", 32'(cmd_if.cmd_ready), 32'd0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    cyc = 0;
    tk  = 1'b0;
    for (int i = 0; i < 2 * FRAME && !tk; i++) begin
      @(negedge clk);
      if (frame_tick) tk = 1'b1;
      else cyc++;
    end
    checkOutput("tick_after_reset", 32'(cyc), 32'(FRAME - 1));
    repeat (NUM_CH + 1) @(negedge clk);
    checkOutput("post_reset_frame", value, 32'h7F7F7F7F);
    checkOutput("post_reset_busy", 32'(busy), 32'd0);

    // Random commands checked by the scoreboard
    for (int n = 0; n < 40; n++) begin
      rch = 2'($urandom_range(0, NUM_CH - 1));
      if ($urandom_range(0, 3) == 0) rtg = ($urandom_range(0, 1) == 1) ? 8'd255 : 8'd0;
      else rtg = 8'($urandom_range(0, 255));
      applyStimulus(1'b1, rch, rtg, st, tk);
      repeat ($urandom_range(0, 30)) @(posedge clk);
    end
    repeat (3) waitTick();
    @(negedge clk);
    checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
